traffic_sampler: RTL

- Front end that feeds Turn_Controller's traffic-count memory interface.
- Counts vehicle detector pulses on street 0 and street 1 over a fixed sample window, then issues a one-cycle write on the controller's logging port.
- Drives the per-street count buses that the controller's timing logic reads continuously.
- Optionally initiates single-entry readbacks from the controller's log and returns the captured data to a host.

---
 rtl/traffic_sampler.sv | 262 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/traffic_sampler.sv
// ---------------------------------------------------------------------------
// traffic_sampler
//
// Front end for Turn_Controller's traffic-count memory interface. Vehicle
// detector pulses on two streets are synchronised, edge-detected and counted
// (saturating at 15) over a fixed window of WINDOW_CYCLES clocks. At each
// window close the counts are published on traffic_Street_0/1 and a one-cycle
// write is issued on the controller's logging port.
//
// Optional feature (macro SAMPLER_READBACK_EN): single-entry readback of the
// controller's log, returned to a host on readback_Data/Valid/Miss. Without
// the macro, the RD_* states are absent, readback_Request is ignored, and
// address/street plus all readback outputs and busy are tied to 0.
//
// Ports:
//   clock, reset           rising-edge clock, asynchronous active-high reset
//   vehicle_Pulse_0/1      raw detector levels (asynchronous to clock)
//   sampling_Enable        1 = run sample windows
//   readback_Request       1-cycle pulse, latches readback_Address/Street
//   traffic_Street         controller read-data return
//   enable, read_Write     controller port enable, 1 = write / 0 = read
//   address, street        controller read address / street select
//   traffic_Street_0/1     last completed window counts
//   readback_Data/Valid    captured log value, 1-cycle valid pulse
//   readback_Miss          requested entry was never written
//   busy                   readback pending or in flight
// ---------------------------------------------------------------------------
module traffic_sampler #(
    parameter int WINDOW_CYCLES = 64,
    parameter int DEPTH         = 128
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       vehicle_Pulse_0,
    input  logic       vehicle_Pulse_1,
    input  logic       sampling_Enable,
    input  logic       readback_Request,
    input  logic [6:0] readback_Address,
    input  logic       readback_Street,
    input  logic [3:0] traffic_Street,
    output logic       enable,
    output logic       read_Write,
    output logic [6:0] address,
    output logic       street,
    output logic [3:0] traffic_Street_0,
    output logic [3:0] traffic_Street_1,
    output logic [3:0] readback_Data,
    output logic       readback_Valid,
    output logic       readback_Miss,
    output logic       busy
);

    localparam int               WIN_W    = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [6:0]       IDX_LAST = 7'(DEPTH - 1);

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_WRITE      = 3'd1;
`ifdef SAMPLER_READBACK_EN
    localparam logic [2:0] ST_RD_ISSUE   = 3'd2;
    localparam logic [2:0] ST_RD_WAIT    = 3'd3;
    localparam logic [2:0] ST_RD_CAPTURE = 3'd4;
`endif

    function automatic logic [3:0] sat_inc(input logic [3:0] count, input logic hit);
        return (hit && (count != 4'hF)) ? count + 4'd1 : count;
    endfunction

    // -----------------------------------------------------------------------
    // Detector inputs: two-flop synchroniser followed by a rising-edge detect.
    // -----------------------------------------------------------------------
    logic [1:0] sync_0, sync_1;
    logic       prev_0, prev_1;
    logic       edge_0, edge_1;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples values from before the clock edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_0 <= '0;
            sync_1 <= '0;
            prev_0 <= 1'b0;
            prev_1 <= 1'b0;
        end else begin
            sync_0 <= {sync_0[0], vehicle_Pulse_0};
            sync_1 <= {sync_1[0], vehicle_Pulse_1};
            prev_0 <= sync_0[1];
            prev_1 <= sync_1[1];
        end
    end

    assign edge_0 = sync_0[1] & ~prev_0;
    assign edge_1 = sync_1[1] & ~prev_1;

    // -----------------------------------------------------------------------
    // Sample window. The closing cycle folds in its own edge and restarts the
    // window at zero on the very next cycle, so no edge falls between windows.
    // -----------------------------------------------------------------------
    logic [WIN_W-1:0] win_cnt;
    logic [3:0]       count_0, count_1;
    logic             window_close;
    logic             write_pending;
    logic [2:0]       state, next_state;

    assign window_close = sampling_Enable && (win_cnt == WIN_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            win_cnt          <= '0;
            count_0          <= 4'd0;
            count_1          <= 4'd0;
            traffic_Street_0 <= 4'd0;
            traffic_Street_1 <= 4'd0;
        end else if (!sampling_Enable) begin
            win_cnt <= '0;
            count_0 <= 4'd0;
            count_1 <= 4'd0;
        end else if (window_close) begin
            traffic_Street_0 <= sat_inc(count_0, edge_0);
            traffic_Street_1 <= sat_inc(count_1, edge_1);
            win_cnt          <= '0;
            count_0          <= 4'd0;
            count_1          <= 4'd0;
        end else begin
            win_cnt <= win_cnt + WIN_W'(1);
            count_0 <= sat_inc(count_0, edge_0);
            count_1 <= sat_inc(count_1, edge_1);
        end
    end

    // A window close that finds the FSM idle goes straight to WRITE on the
    // same edge; otherwise the flag holds the write until the FSM returns.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            write_pending <= 1'b0;
        end else if (window_close) begin
            write_pending <= 1'b1;
        end else if (state == ST_WRITE) begin
            write_pending <= 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Log write index. wrapped marks that every entry has been written once.
    // -----------------------------------------------------------------------
    logic [6:0] write_index;
    logic       wrapped;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            write_index <= 7'd0;
            wrapped     <= 1'b0;
        end else if (state == ST_WRITE) begin
            if (write_index == IDX_LAST) begin
                write_index <= 7'd0;
                wrapped     <= 1'b1;
            end else begin
                write_index <= write_index + 7'd1;
            end
        end
    end

`ifdef SAMPLER_READBACK_EN
    // -----------------------------------------------------------------------
    // Readback request latch. The miss decision is taken against the log
    // state at request time; the bus read still runs to keep latency fixed.
    // -----------------------------------------------------------------------
    logic       rd_pending;
    logic [6:0] rd_addr;
    logic       rd_street;
    logic       rd_miss;
    logic       accept;

    assign busy   = rd_pending || (state == ST_RD_ISSUE) ||
                    (state == ST_RD_WAIT) || (state == ST_RD_CAPTURE);
    assign accept = readback_Request && !busy;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_pending <= 1'b0;
            rd_addr    <= 7'd0;
            rd_street  <= 1'b0;
            rd_miss    <= 1'b0;
        end else if (accept) begin
            rd_pending <= 1'b1;
            rd_addr    <= readback_Address;
            rd_street  <= readback_Street;
            rd_miss    <= !wrapped && (readback_Address >= write_index);
        end else if (state == ST_RD_ISSUE) begin
            rd_pending <= 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            readback_Data  <= 4'd0;
            readback_Miss  <= 1'b0;
            readback_Valid <= 1'b0;
        end else begin
            readback_Valid <= (state == ST_RD_CAPTURE);
            if (state == ST_RD_CAPTURE) begin
                readback_Data <= rd_miss ? 4'd0 : traffic_Street;
                readback_Miss <= rd_miss;
            end
        end
    end

    assign address = (state == ST_RD_ISSUE) ? rd_addr : 7'd0;
    assign street  = (state == ST_RD_ISSUE) ? rd_street : 1'b0;
    assign enable  = (state == ST_WRITE) || (state == ST_RD_ISSUE);
`else
    wire unused_readback = ^{readback_Request, readback_Address, readback_Street,
                             traffic_Street, write_index, wrapped};

    assign readback_Data  = 4'd0;
    assign readback_Valid = 1'b0;
    assign readback_Miss  = 1'b0;
    assign busy           = 1'b0;
    assign address        = 7'd0;
    assign street         = 1'b0;
    assign enable         = (state == ST_WRITE);
`endif

    assign read_Write = (state == ST_WRITE);

    // -----------------------------------------------------------------------
    // Port FSM. Writes always win over readbacks.
    // -----------------------------------------------------------------------
    // NOTE: next_state gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (write_pending || window_close) begin
                    next_state = ST_WRITE;
                end
`ifdef SAMPLER_READBACK_EN
                else if (rd_pending) begin
                    next_state = ST_RD_ISSUE;
                end
`endif
            end
            ST_WRITE:      next_state = ST_IDLE;
`ifdef SAMPLER_READBACK_EN
            ST_RD_ISSUE:   next_state = ST_RD_WAIT;
            ST_RD_WAIT:    next_state = ST_RD_CAPTURE;
            ST_RD_CAPTURE: next_state = ST_IDLE;
`endif
            default:       next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

endmodule
